// File: rtl/bit4_alu_rsp_if.sv
// Request/result handshake bundle for bit4_alu_rsp.
// master drives requests and drains results; slave is the responder.
interface bit4_alu_rsp_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] y;
    logic       err;

    modport master (
        output in_valid,
        output a,
        output b,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  err
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output err
    );
endinterface

// File: rtl/bit4_alu_rsp.sv
// Handshaked 4-bit ALU responder with a 2-entry in-order result buffer.
// Optional saturating illegal-opcode counter: define BIT4_ALU_RSP_ERR_CNT_EN.
module bit4_alu_rsp #(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
`ifdef BIT4_ALU_RSP_ERR_CNT_EN
    bit4_alu_rsp_if.slave bus,
    output logic [7:0]    err_cnt
`else
    bit4_alu_rsp_if.slave bus
`endif
);

    logic [4:0] y_mem   [2];
    logic       err_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic       push;
    logic       pop;
    logic [4:0] res;
    logic       ill;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Ready depends only on occupancy, so out_ready never reaches in_ready.
    assign bus.in_ready  = (count != 2'(DEPTH));
    assign bus.out_valid = (count != 2'd0);
    assign bus.y         = y_mem[rd_ptr];
    assign bus.err       = err_mem[rd_ptr];

    always_comb begin
        res = 5'd0;
        ill = 1'b0;
        case (bus.sel)
            4'b0000: res = {1'b0, bus.a} + {1'b0, bus.b};
            4'b0001: res = {1'b0, bus.a} - {1'b0, bus.b};
            4'b0010: res = {1'b0, bus.a & bus.b};
            4'b0011: res = {1'b0, bus.a | bus.b};
            4'b0100: res = {1'b0, bus.a ^ bus.b};
            4'b0101: res = {1'b0, ~(bus.a ^ bus.b)};
            4'b0110: res = {1'b0, ~bus.a};
            4'b0111: res = {bus.a, 1'b0};
            4'b1000: res = {2'b00, bus.a[3:1]};
            default: ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            y_mem[0]   <= 5'd0;
            y_mem[1]   <= 5'd0;
            err_mem[0] <= 1'b0;
            err_mem[1] <= 1'b0;
        end else begin
            if (push) begin
                y_mem[wr_ptr]   <= res;
                err_mem[wr_ptr] <= ill;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef BIT4_ALU_RSP_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (push && ill && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bit4_alu_rsp.sv
// Directed self-checking bench for bit4_alu_rsp.
// Hand-computed vectors; immediate assertions at every check point.
module tb_bit4_alu_rsp;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    bit4_alu_rsp_if bus ();

`ifdef BIT4_ALU_RSP_ERR_CNT_EN
    logic [7:0] err_cnt;
    bit4_alu_rsp #(.DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );
`else
    bit4_alu_rsp #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] s);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.sel      = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with out_ready high: the result is at the head after the edge.
    task automatic step(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] s,
                        input logic [4:0] ey, input logic ee);
        drive(1'b1, a, b, s);
        tick();
        chk({tag, "_vld"}, 8'(bus.out_valid), 8'd1);
        chk({tag, "_y"}, 8'(bus.y), 8'(ey));
        chk({tag, "_err"}, 8'(bus.err), 8'(ee));
        chk({tag, "_rdy"}, 8'(bus.in_ready), 8'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        #1;
        chk("rst_in_ready", 8'(bus.in_ready), 8'd1);
        chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_y", 8'(bus.y), 8'd0);
        chk("rst_err", 8'(bus.err), 8'd0);
`ifdef BIT4_ALU_RSP_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 8'd0);
`endif
        #22;
        rst = 1'b0;
        tick();

        // add, then empty again
        bus.out_ready = 1'b1;
        step("add", 4'b0011, 4'b1001, 4'b0000, 5'b01100, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("add_drain", 8'(bus.out_valid), 8'd0);

        // sub with and without borrow, back to back
        step("sub0", 4'b1010, 4'b1001, 4'b0001, 5'b00001, 1'b0);
        step("sub1", 4'b0010, 4'b0110, 4'b0001, 5'b11100, 1'b0);

        // streaming at one per cycle
        step("and", 4'b1111, 4'b1010, 4'b0010, 5'b01010, 1'b0);
        step("shl", 4'b1111, 4'b0000, 4'b0111, 5'b11110, 1'b0);
        step("shr", 4'b1010, 4'b0000, 4'b1000, 5'b00101, 1'b0);
        step("or", 4'b0101, 4'b1010, 4'b0011, 5'b01111, 1'b0);
        step("xor", 4'b1100, 4'b1010, 4'b0100, 5'b00110, 1'b0);
        step("xnor", 4'b1100, 4'b1010, 4'b0101, 5'b01001, 1'b0);
        step("not", 4'b0101, 4'b1111, 4'b0110, 5'b01010, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("stream_drain", 8'(bus.out_valid), 8'd0);

        // backpressure: fill, hold third request, then drain
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd1, 4'd1, 4'b0000);
        tick();
        chk("bp1_rdy", 8'(bus.in_ready), 8'd1);
        chk("bp1_y", 8'(bus.y), 8'h02);
        drive(1'b1, 4'd1, 4'd2, 4'b0001);
        tick();
        chk("bp2_rdy", 8'(bus.in_ready), 8'd0);
        chk("bp2_y", 8'(bus.y), 8'h02);
        drive(1'b1, 4'd8, 4'd1, 4'b0011);
        tick();
        chk("bp3_rdy", 8'(bus.in_ready), 8'd0);
        chk("bp3_y_hold", 8'(bus.y), 8'h02);
        chk("bp3_vld", 8'(bus.out_valid), 8'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_pop1_y", 8'(bus.y), 8'h1F);
        chk("bp_pop1_rdy", 8'(bus.in_ready), 8'd1);
        tick();
        chk("bp_pop2_y", 8'(bus.y), 8'h09);
        chk("bp_pop2_vld", 8'(bus.out_valid), 8'd1);
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("bp_drain", 8'(bus.out_valid), 8'd0);

        // illegal opcode
        step("ill", 4'b0101, 4'b0011, 4'b1010, 5'b00000, 1'b1);
`ifdef BIT4_ALU_RSP_ERR_CNT_EN
        chk("err_cnt_1", err_cnt, 8'd1);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'(i), 4'd0, 4'(9 + (i % 7)));
            tick();
        end
        chk("err_cnt_sat", err_cnt, 8'd255);
`endif
        step("legal_after", 4'b0001, 4'b0001, 4'b0000, 5'b00010, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();

        // asynchronous reset with a full buffer
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd3, 4'd3, 4'b0000);
        tick();
        tick();
        chk("full_rdy", 8'(bus.in_ready), 8'd0);
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", 8'(bus.out_valid), 8'd0);
        chk("arst_rdy", 8'(bus.in_ready), 8'd1);
        chk("arst_y", 8'(bus.y), 8'd0);
`ifdef BIT4_ALU_RSP_ERR_CNT_EN
        chk("arst_err_cnt", err_cnt, 8'd0);
`endif
        tick();
        #3;
        rst = 1'b0;
        tick();
        chk("post_rst_empty", 8'(bus.out_valid), 8'd0);
        bus.out_ready = 1'b1;
        step("post_rst", 4'd7, 4'd7, 4'b0000, 5'b01110, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        chk("post_rst_drain", 8'(bus.out_valid), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
